rlbp_code_collector: RTL and testbench
======================================

Name: rlbp_code_collector

Overview:
- Downstream consumer of the RLBP sampling stage.
- Deserialises comparator decisions, one bit per sample strobe, into NBITS-wide LBP codes.
- Tags each code with a wrapping pixel index and buffers it in a first-word-fall-through FIFO, so firmware can drain it over Wishbone/LA without losing codes between reads.
- Raises a level interrupt when the FIFO fill reaches a programmable threshold.

Parameters:
- NBITS, 8, comparator samples per LBP code.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- PIX_W, 12, pixel index width; matches the 12-bit counter domain.

Ports:
- clk  in  1  single clock for the block.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush: drops the partial code, FIFO contents, pixel index and overflow.
- sample_valid  in  1  one-cycle strobe; sample_bit is valid this cycle.
- sample_bit  in  1  comparator decision.
- rd_en  in  1  pop the head entry.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  PIX_W+NBITS  {pixel_idx, code} of the head entry; adds +1 bit with the option.
- level  out  $clog2(DEPTH+1)  current entry count.
- thresh  in  $clog2(DEPTH+1)  interrupt threshold; 0 disables the interrupt.
- irq  out  1  level-sensitive: high while thresh!=0 and level>=thresh.
- overflow  out  1  sticky; set when a completed code is dropped because the FIFO is full.

Behaviour:
- Reset (rst_n=0, async) sets:
  - bit_cnt=0, shift=0, pixel_idx=0;
  - FIFO empty, level=0, rd_valid=0, rd_data=0;
  - overflow=0, irq=0.
- Deserialiser:
  - On sample_valid: shift <= {shift[NBITS-2:0], sample_bit}. The first bit becomes the MSB, matching the shift direction of the sampling stage.
  - bit_cnt increments on each sample_valid. On the sample where bit_cnt==NBITS-1 the code is complete: bit_cnt <= 0, and a push request is issued carrying code={shift[NBITS-2:0], sample_bit} and the current pixel_idx.
  - pixel_idx increments on every completed code, whether it is accepted or dropped.
  - pixel_idx wraps from 2**PIX_W-1 to 0.
- Latency: entry pushed on edge N; rd_valid=1 and rd_data valid after edge N (i.e. visible during cycle N+1).
- FIFO:
  - Registered pointers with an extra wrap bit; level = wptr-rptr.
  - rd_data is always the head entry (first-word fall-through).
  - rd_data holds its last value when the FIFO is empty; a bench must not check it unless rd_valid=1.
- Pop: rd_en && rd_valid advances rptr. rd_en while empty is ignored, with no state change.
- Push while full:
  - If a pop happens in the same cycle, the push is accepted and level is unchanged.
  - Otherwise the code is dropped and overflow <= 1.
- Simultaneous push and pop when not full: both happen and level is unchanged.
- Push and pop on an empty FIFO: the push is accepted and the pop is ignored (rd_valid was 0), so level becomes 1.
- clear:
  - Has priority over sample_valid and rd_en in the same cycle.
  - That cycle's sample is discarded.
  - Clears overflow, bit_cnt, shift, pixel_idx and the pointers.
- irq is combinational from registered level and the thresh input; no extra latency.
- An async reset mid-code discards the partial bits; no push occurs.

Optional Feature:
- Macro RLBP_COLLECTOR_PARITY_EN.
- Defined: each entry is widened by 1 bit. The MSB of rd_data is the even parity of the code bits, computed at push time, so rd_data width is PIX_W+NBITS+1.
- Undefined: no parity bit and no parity logic; rd_data width is PIX_W+NBITS.

Decomposition:
- Shared package rlbp_pkg (or an `include of localparams) holds:
  - RLBP_NBITS=8 and RLBP_PIX_W=12;
  - the entry field offsets (CODE_LSB=0, IDX_LSB=NBITS, PAR_BIT);
  - the log2 helper for level width.
- One natural sub-module: rlbp_sync_fifo, a parameterised WIDTH/DEPTH FWFT FIFO with push, pop, full, empty and level.
- The deserialiser, pixel counter, overflow flag and irq logic stay in the top.

Test Plan:
1. Reset, then 8 strobes with bits 1,0,1,1,0,0,1,0 → one cycle after the 8th strobe: rd_valid=1, rd_data={12'd0, 8'hB2}, level=1; with parity option, MSB=0.
2. 17 codes with no reads (DEPTH=16) → level=16 after the 16th code; 17th code dropped, overflow=1. Pop all → indices 0..15 in order; a new code then carries idx 17.
3. FIFO full, the 8th strobe of a code coincides with rd_en → level stays 16, overflow stays 0, and the new entry appears last.
4. thresh=4, push 4 codes → irq rises in the same cycle level becomes 4. One pop → irq=0. thresh=0 → irq never asserts.
5. 5 strobes then clear, then 8 strobes of 0xFF → exactly one entry {0, 8'hFF}, overflow=0. clear coinciding with a sample_valid → that sample is ignored.
6. Generate 4096 codes, popping every cycle → pixel_idx runs 4095 then wraps to 0. rd_en on an empty FIFO leaves level=0 and pointers unchanged. rst_n asserted mid-code → all outputs 0 immediately.

Source files
------------

// File: rtl/rlbp_pkg.sv
// Shared constants and helpers for the RLBP code collector.
// Entry layout: {parity (RLBP_COLLECTOR_PARITY_EN only), pixel_idx, code}.
package rlbp_pkg;

    localparam int RLBP_NBITS = 8;
    localparam int RLBP_PIX_W = 12;

    localparam int CODE_LSB = 0;
    localparam int IDX_LSB  = RLBP_NBITS;
    localparam int PAR_BIT  = RLBP_NBITS + RLBP_PIX_W;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rlbp_sync_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers.
// A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
module rlbp_sync_fifo
    import rlbp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [lvl_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = LW'(wptr - rptr);
    assign dout  = mem[rptr[AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= din;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rlbp_code_collector.sv
// Deserialises comparator bits into pixel-tagged LBP codes and queues them.
// Define RLBP_COLLECTOR_PARITY_EN to append an even-parity bit as the entry MSB.
module rlbp_code_collector
    import rlbp_pkg::*;
#(
    parameter int NBITS = RLBP_NBITS,
    parameter int DEPTH = 16,
    parameter int PIX_W = RLBP_PIX_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    sample_valid,
    input  logic                    sample_bit,
    input  logic                    rd_en,
    output logic                    rd_valid,
`ifdef RLBP_COLLECTOR_PARITY_EN
    output logic [PIX_W+NBITS:0]    rd_data,
`else
    output logic [PIX_W+NBITS-1:0]  rd_data,
`endif
    output logic [lvl_w(DEPTH)-1:0] level,
    input  logic [lvl_w(DEPTH)-1:0] thresh,
    output logic                    irq,
    output logic                    overflow
);

`ifdef RLBP_COLLECTOR_PARITY_EN
    localparam int EW = PIX_W + NBITS + 1;
`else
    localparam int EW = PIX_W + NBITS;
`endif
    localparam int CW = $clog2(NBITS);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    logic [CW-1:0]    bit_cnt;
    logic [NBITS-2:0] shift;
    logic [PIX_W-1:0] pixel_idx;
    logic [NBITS-1:0] code;
    logic [EW-1:0]    entry;
    logic             complete;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign code     = {shift, sample_bit};
    assign complete = sample_valid && (bit_cnt == LAST);
    assign push     = complete && !clear;
    assign pop      = rd_en && !clear;

`ifdef RLBP_COLLECTOR_PARITY_EN
    assign entry = {^code, pixel_idx, code};
`else
    assign entry = {pixel_idx, code};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift     <= '0;
            pixel_idx <= '0;
        end else if (clear) begin
            bit_cnt   <= '0;
            shift     <= '0;
            pixel_idx <= '0;
        end else if (sample_valid) begin
            shift <= code[NBITS-2:0];
            if (complete) begin
                bit_cnt   <= '0;
                pixel_idx <= pixel_idx + 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // A full FIFO only drops the code when no pop frees a slot this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (push && full && !(pop && rd_valid)) begin
            overflow <= 1'b1;
        end
    end

    rlbp_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (entry),
        .dout  (rd_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign rd_valid = !empty;
    assign irq      = (thresh != '0) && (level >= thresh);

endmodule

// File: tb/tb_rlbp_code_collector.sv
// Randomised bench for rlbp_code_collector against a queue-based model.
// Honours RLBP_COLLECTOR_PARITY_EN for the entry layout.
module tb_rlbp_code_collector;
    import rlbp_pkg::*;

    localparam int NB    = 8;
    localparam int DEPTH = 16;
    localparam int PW    = 12;
    localparam int LW    = lvl_w(DEPTH);
`ifdef RLBP_COLLECTOR_PARITY_EN
    localparam int EW = PW + NB + 1;
`else
    localparam int EW = PW + NB;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          sample_valid = 1'b0;
    logic          sample_bit = 1'b0;
    logic          rd_en = 1'b0;
    logic          rd_valid;
    logic [EW-1:0] rd_data;
    logic [LW-1:0] level;
    logic [LW-1:0] thresh = '0;
    logic          irq;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    rlbp_code_collector #(
        .NBITS (NB),
        .DEPTH (DEPTH),
        .PIX_W (PW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .sample_valid (sample_valid),
        .sample_bit   (sample_bit),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .level        (level),
        .thresh       (thresh),
        .irq          (irq),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input int idx, input int code);
        logic [EW-1:0] e;
        logic [7:0]    c;
        c = code[7:0];
        e = '0;
        e[NB+PW-1:0] = {idx[PW-1:0], c};
`ifdef RLBP_COLLECTOR_PARITY_EN
        e[EW-1] = ^c;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of entries, a bit counter and an index.
    logic [EW-1:0] q[$];
    int            m_cnt;
    int            m_code;
    int            m_idx;
    bit            m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_cnt  = 0;
            m_code = 0;
            m_idx  = 0;
            m_ovf  = 0;
        end else if (clear) begin
            q.delete();
            m_cnt  = 0;
            m_code = 0;
            m_idx  = 0;
            m_ovf  = 0;
        end else begin
            bit popped;
            popped = rd_en && q.size() > 0;
            if (popped) void'(q.pop_front());
            if (sample_valid) begin
                m_code = ((m_code << 1) | int'(sample_bit)) & 8'hFF;
                m_cnt++;
                if (m_cnt == NB) begin
                    if (q.size() < DEPTH) q.push_back(mk(m_idx, m_code));
                    else m_ovf = 1;
                    m_idx  = (m_idx + 1) % (1 << PW);
                    m_cnt  = 0;
                    m_code = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd_valid", rd_valid, q.size() != 0);
            chk("level", level, q.size());
            chk("overflow", overflow, m_ovf);
            chk("irq", irq, thresh != 0 && q.size() >= thresh);
            if (q.size() != 0) chk("rd_data", rd_data, q[0]);
        end
    end

    task automatic drive(input bit sv, input bit sb, input bit re,
                         input bit clr);
        sample_valid = sv;
        sample_bit   = sb;
        rd_en        = re;
        clear        = clr;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sample_bit   = 1'b0;
        rd_en        = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic send_code(input int code, input bit re_last);
        for (int i = NB - 1; i >= 0; i--) begin
            drive(1'b1, code[i], re_last && i == 0, 1'b0);
        end
    endtask

    function automatic int idx_of(input logic [EW-1:0] e);
        return int'(e[IDX_LSB +: PW]);
    endfunction

    initial begin
        int      c;
        int      code_b2;
        int      head;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_level", level, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ovf", overflow, 0);

        code_b2 = 32'hB2;
        send_code(code_b2, 1'b0);
        chk("t1_valid", rd_valid, 1);
        chk("t1_data", rd_data[NB+PW-1:0], {12'd0, 8'hB2});
        chk("t1_level", level, 1);
`ifdef RLBP_COLLECTOR_PARITY_EN
        chk("t1_par", rd_data[EW-1], 0);
`endif

        drive(0, 0, 0, 1);
        for (int i = 0; i < 17; i++) begin
            send_code(int'($urandom_range(0, 255)), 1'b0);
            if (i == 15) chk("t2_full_level", level, 16);
            if (i == 15) chk("t2_no_ovf", overflow, 0);
        end
        chk("t2_level", level, 16);
        chk("t2_ovf", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            chk("t2_idx", idx_of(rd_data), i);
            drive(0, 0, 1, 0);
        end
        chk("t2_empty", rd_valid, 0);
        send_code(8'h5A, 1'b0);
        chk("t2_idx17", idx_of(rd_data), 17);

        drive(0, 0, 0, 1);
        for (int i = 0; i < 16; i++) send_code(int'($urandom_range(0, 255)), 1'b0);
        send_code(8'h3C, 1'b1);
        chk("t3_level", level, 16);
        chk("t3_ovf", overflow, 0);
        chk("t3_head", idx_of(rd_data), 1);
        for (int i = 0; i < 15; i++) drive(0, 0, 1, 0);
        chk("t3_last", rd_data, mk(16, 8'h3C));

        drive(0, 0, 0, 1);
        thresh = LW'(4);
        for (int i = 0; i < 3; i++) send_code(i, 1'b0);
        chk("t4_irq_lo", irq, 0);
        send_code(3, 1'b0);
        chk("t4_irq_hi", irq, 1);
        drive(0, 0, 1, 0);
        chk("t4_irq_pop", irq, 0);
        thresh = '0;
        for (int i = 0; i < 6; i++) send_code(i, 1'b0);
        chk("t4_irq_off", irq, 0);

        drive(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0);
        drive(0, 0, 0, 1);
        send_code(8'hFF, 1'b0);
        chk("t5_level", level, 1);
        chk("t5_data", rd_data, mk(0, 8'hFF));
        chk("t5_ovf", overflow, 0);
        drive(1, 1, 0, 1);
        for (int i = 0; i < 7; i++) drive(1, 0, 0, 0);
        chk("t5_none", level, 0);
        drive(1, 0, 0, 0);
        chk("t5_one", rd_data, mk(0, 0));

        drive(0, 0, 0, 1);
        for (int i = 0; i < 4096; i++) begin
            c = int'($urandom_range(0, 255));
            for (int b = NB - 1; b >= 0; b--) drive(1, c[b], 1, 0);
            if (i == 4095) chk("t6_4095", idx_of(rd_data), 4095);
        end
        drive(0, 0, 1, 0);
        send_code(8'h81, 1'b0);
        chk("t6_wrap", rd_data, mk(0, 8'h81));

        drive(0, 0, 0, 1);
        drive(0, 0, 1, 0);
        chk("t6_empty_lvl", level, 0);
        chk("t6_empty_vld", rd_valid, 0);
        send_code(8'h11, 1'b0);
        chk("t6_after", rd_data, mk(0, 8'h11));
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", rd_valid, 0);
        chk("t6_rst_lvl", level, 0);
        chk("t6_rst_data", rd_data, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_irq", irq, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_code(8'h42, 1'b0);
        chk("t6_post_rst", rd_data, mk(0, 8'h42));

        thresh = LW'($urandom_range(0, DEPTH));
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) thresh = LW'($urandom_range(0, DEPTH));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
        end

        head = q.size();
        chk("final_level", level, head);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
